adsr_envelope: RTL and testbench

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

---
 rtl/adsr_envelope_if.sv | 34 +++
 rtl/adsr_envelope.sv | 131 +++++++++++++
 tb/tb_adsr_envelope.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: signal bundle between an ADSR envelope and whoever drives it.
//   sample_clock  sample-rate square wave, synchronous to clk
//   gate          1 = key held, 0 = key released
//   attack/decay/release_rate  per-tick step minus one
//   sustain       sustain level, upper byte of the 16-bit target
//   in            signed oscillator sample
//   out           signed enveloped sample (registered)
//   level         envelope level, upper byte of the internal 16-bit level
//   state         envelope phase encoding
// The release rate is named release_rate because "release" is a reserved word.
interface adsr_envelope_if #(
  parameter int BITDEPTH = 14
);
  logic                       sample_clock;
  logic                       gate;
  logic [7:0]                 attack;
  logic [7:0]                 decay;
  logic [7:0]                 sustain;
  logic [7:0]                 release_rate;
  logic signed [BITDEPTH-1:0] in;
  logic signed [BITDEPTH-1:0] out;
  logic [7:0]                 level;
  logic [2:0]                 state;

  modport master (
    output sample_clock, gate, attack, decay, sustain, release_rate, in,
    input  out, level, state
  );

  modport slave (
    input  sample_clock, gate, attack, decay, sustain, release_rate, in,
    output out, level, state
  );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope applied to an oscillator sample.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    adsr_envelope_if slave: rates, sustain, gate, sample tick source,
//          input sample in; enveloped sample, level and state out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | envelope silent, lvl held at 0
// ATTACK  | lvl rising by attack+1 per tick up to 16'hFFFF
// DECAY   | lvl falling by decay+1 per tick down to the sustain target
// SUSTAIN | lvl tracks {sustain, 8'h00} every tick
// RELEASE | lvl falling by release_rate+1 per tick down to 0
module adsr_envelope #(
  parameter int BITDEPTH = 14
) (
  input logic             clk,
  input logic             rst_n,
  adsr_envelope_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t      state_q, state_nxt;
  logic [15:0] lvl_q, lvl_nxt;
  logic        sc_d;
  logic        sc_armed;
  logic        tick;

  logic [15:0] s16;
  logic [8:0]  att_step, dec_step, rel_step;
  logic [16:0] att_sum, dec_thr;

  logic signed [BITDEPTH+8:0] prod;
  logic                       unused_prod_bits;

  // sc_d resets low, so a sample_clock already high at reset release would
  // look like a rising edge. sc_armed blocks ticks until sample_clock has
  // been seen low at least once after reset.
  assign tick = bus.sample_clock & ~sc_d & sc_armed;

  assign s16      = {bus.sustain, 8'h00};
  assign att_step = {1'b0, bus.attack} + 9'd1;
  assign dec_step = {1'b0, bus.decay} + 9'd1;
  assign rel_step = {1'b0, bus.release_rate} + 9'd1;
  assign att_sum  = {1'b0, lvl_q} + {8'b0, att_step};
  assign dec_thr  = {1'b0, s16} + {8'b0, dec_step};

  always_comb begin
    state_nxt = state_q;
    lvl_nxt   = lvl_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (bus.gate) state_nxt = ATTACK;
          else          lvl_nxt   = 16'h0000;
        end
        ATTACK: begin
          if (!bus.gate) begin
            state_nxt = RELEASE;
          end else if (att_sum >= 17'h0FFFF) begin
            lvl_nxt   = 16'hFFFF;
            state_nxt = DECAY;
          end else begin
            lvl_nxt = att_sum[15:0];
          end
        end
        DECAY: begin
          if (!bus.gate) begin
            state_nxt = RELEASE;
          end else if ({1'b0, lvl_q} <= dec_thr) begin
            lvl_nxt   = s16;
            state_nxt = SUSTAIN;
          end else begin
            lvl_nxt = lvl_q - {7'b0, dec_step};
          end
        end
        SUSTAIN: begin
          if (!bus.gate) state_nxt = RELEASE;
          else           lvl_nxt   = s16;
        end
        RELEASE: begin
          if (bus.gate) begin
            // retrigger resumes the attack from the current level
            state_nxt = ATTACK;
          end else if (lvl_q <= {7'b0, rel_step}) begin
            lvl_nxt   = 16'h0000;
            state_nxt = IDLE;
          end else begin
            lvl_nxt = lvl_q - {7'b0, rel_step};
          end
        end
        default: begin
          state_nxt = IDLE;
          lvl_nxt   = 16'h0000;
        end
      endcase
    end
  end

  // Signed sample times unsigned 8-bit level; taking bits [BITDEPTH+7:8]
  // is the arithmetic shift right by 8 followed by truncation.
  assign prod             = bus.in * $signed({1'b0, lvl_q[15:8]});
  assign unused_prod_bits = ^{prod[7:0], prod[BITDEPTH+8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_d     <= 1'b0;
      sc_armed <= 1'b0;
      state_q  <= IDLE;
      lvl_q    <= 16'h0000;
      bus.out  <= '0;
    end else begin
      sc_d     <= bus.sample_clock;
      sc_armed <= sc_armed | ~bus.sample_clock;
      state_q  <= state_nxt;
      lvl_q    <= lvl_nxt;
      bus.out  <= prod[BITDEPTH+7:8];
    end
  end

  assign bus.level = lvl_q[15:8];
  assign bus.state = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed self-checking bench for adsr_envelope.
`timescale 1ns/1ps
module tb_adsr_envelope;
  localparam int BITDEPTH = 14;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adsr_envelope_if #(.BITDEPTH(BITDEPTH)) bus ();

  adsr_envelope #(.BITDEPTH(BITDEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #62.5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one sample_clock pulse (1 clk high, 1 clk low); returns on a falling clk edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sample_clock = 1'b1;
      @(negedge clk);
      bus.sample_clock = 1'b0;
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.sample_clock = 1'b1;
    bus.gate         = 1'b0;
    bus.attack       = 8'd255;
    bus.decay        = 8'd255;
    bus.sustain      = 8'h80;
    bus.release_rate = 8'd127;
    bus.in           = 14'sd8191;

    repeat (3) @(negedge clk);
    check("reset_out",   bus.out,   0);
    check("reset_level", bus.level, 0);
    check("reset_state", bus.state, 0);

    // release reset with sample_clock already high: no tick until it falls and rises
    rst_n    = 1'b1;
    bus.gate = 1'b1;
    repeat (1000) @(negedge clk);
    check("hold_high_state", bus.state, 0);
    check("hold_high_level", bus.level, 0);
    bus.sample_clock = 1'b0;
    repeat (3) @(negedge clk);
    check("after_low_state", bus.state, 0);

    // attack, step 256 per tick
    tick(1);
    check("att_first_state", bus.state, 1);
    check("att_first_level", bus.level, 0);
    tick(255);                                  // 255*256 = 16'hFF00
    check("att_ff00_state", bus.state, 1);
    check("att_ff00_level", bus.level, 8'hFF);
    tick(1);                                    // 0xFF00+256 saturates
    check("att_sat_state", bus.state, 2);
    check("att_sat_level", bus.level, 8'hFF);

    // out = (in*255)>>>8 : 8191*255=2088705 -> 8159 ; -8192*255=-2088960 -> -8160
    @(negedge clk);
    check("out_pos", bus.out, 8159);
    bus.in = -14'sd8192;
    @(negedge clk);
    check("out_neg", bus.out, -8160);
    bus.in = 14'sd8191;
    @(negedge clk);

    // decay by 256 from 16'hFFFF to 16'h8000: 127 steps reach 16'h80FF
    tick(127);
    check("dec_80ff_state", bus.state, 2);
    check("dec_80ff_level", bus.level, 8'h80);
    tick(1);
    check("dec_sus_state", bus.state, 3);
    check("dec_sus_level", bus.level, 8'h80);
    bus.sustain = 8'h40;
    @(negedge clk);
    check("sus_change_hold", bus.level, 8'h80);
    tick(1);
    check("sus_change_level", bus.level, 8'h40);
    check("sus_change_state", bus.state, 3);
    bus.sustain = 8'h80;
    tick(1);
    check("sus_back_level", bus.level, 8'h80);

    // release by 128 from 16'h8000: 256 steps to zero
    bus.gate = 1'b0;
    tick(1);
    check("rel_entry_state", bus.state, 4);
    check("rel_entry_level", bus.level, 8'h80);
    tick(255);                                  // lvl = 128
    check("rel_255_state", bus.state, 4);
    check("rel_255_level", bus.level, 0);
    tick(1);
    check("rel_done_state", bus.state, 0);
    check("rel_done_level", bus.level, 0);
    @(negedge clk);
    check("rel_done_out", bus.out, 0);

    // sample_clock period of 256 clks: exactly one tick per rising edge
    bus.gate = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      bus.sample_clock = 1'b1;
      repeat (127) @(negedge clk);
      bus.sample_clock = 1'b0;
      repeat (128) @(negedge clk);
      check("div256_state", bus.state, 1);
      check("div256_level", bus.level, p);
    end

    // retrigger from RELEASE at 16'h2000 (lvl now 16'h0300)
    tick(29);
    check("pre_retrig_level", bus.level, 8'h20);
    bus.gate = 1'b0;
    tick(1);
    check("retrig_rel_state", bus.state, 4);
    bus.gate = 1'b1;
    tick(1);
    check("retrig_state", bus.state, 1);
    check("retrig_level", bus.level, 8'h20);
    tick(1);
    check("retrig_step_level", bus.level, 8'h21);

    // 8191*33 = 270303 -> 1055 ; then async reset between clock edges
    @(negedge clk);
    check("retrig_out", bus.out, 1055);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out",   bus.out,   0);
    check("async_rst_level", bus.level, 0);
    check("async_rst_state", bus.state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
